demux_write_scheduler: RTL

- Shares the single 32-way write-strobe demultiplexer (5-bit Sel, Enable, 1-bit DemuxIn) and its companion data bus among NUM_REQ requesters, such as CPU writeback, DMA and the debug port.
- Arbitrates round-robin, registers the winning target/data, and drives Sel/Enable/DemuxIn for exactly one accepted cycle per request.
- Sits between the requesters and the demux that decodes register or peripheral write strobes.

---
 rtl/demux_write_scheduler_pkg.sv | 20 ++
 rtl/demux_write_scheduler_rr_arbiter.sv | 41 ++++
 rtl/demux_write_scheduler.sv | 105 ++++++++++
 3 files changed

// File: rtl/demux_write_scheduler_pkg.sv
// Shared types and helpers for the demux write scheduler.
// State encoding, default widths and a constant-foldable clog2.
package demux_write_scheduler_pkg;

  localparam int SEL_WIDTH_DEF  = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/demux_write_scheduler_rr_arbiter.sv
// Round-robin arbiter: lowest requester at or above ptr_i wins, else lowest overall.
// Purely combinational; grant is one-hot, any_o flags a valid winner.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] mask;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      mask[i] = (IW'(i) >= ptr_i);
    end
  end

  assign req_hi = req_i & mask;
  // Fall back to the unmasked vector so the search wraps past the top requester.
  assign pick   = (|req_hi) ? req_hi : req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pick[i] && !any_o) begin
        any_o    = 1'b1;
        idx_o    = IW'(i);
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_write_scheduler.sv
// Shares one write-strobe demux among NUM_REQ requesters with round-robin arbitration.
// One-cycle issue latency; a stalled issue holds its fields and blocks new grants.
module demux_write_scheduler
  import demux_write_scheduler_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = 16,
  localparam int IDW       = clog2(NUM_REQ)
) (
  input  logic                          Clock,
  input  logic                          Reset_n,
  input  logic [NUM_REQ-1:0]            ReqValid,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]  ReqSel,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] ReqData,
  output logic [NUM_REQ-1:0]            ReqReady,
  input  logic                          Stall,
  output logic [SEL_WIDTH-1:0]          Sel,
  output logic                          Enable,
  output logic                          DemuxIn,
  output logic [DATA_WIDTH-1:0]         WriteData,
  output logic [IDW-1:0]                GrantId,
  output logic [CNT_WIDTH-1:0]          IssueCount
);

  state_e                state_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDW-1:0]        gid_q;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     win_idx;
  logic               win_any;
  logic               slot_free;
  logic               accept;
  logic               consume;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IDW)
  ) u_arb (
    .req_i (ReqValid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  assign slot_free = (state_q == ST_IDLE) | ((state_q == ST_ISSUE) & ~Stall);
  assign consume   = (state_q == ST_ISSUE) & ~Stall;
  // Reset gates the handshake so nothing is accepted into a register being cleared.
  assign accept    = Reset_n & slot_free & win_any;
  assign ReqReady  = accept ? gnt : '0;

  assign ptr_d = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);
  assign cnt_d = cnt_q + CNT_WIDTH'(1);

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      if (consume) begin
        cnt_q <= cnt_d;
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q <= ST_ISSUE;
            sel_q   <= ReqSel[win_idx*SEL_WIDTH +: SEL_WIDTH];
            data_q  <= ReqData[win_idx*DATA_WIDTH +: DATA_WIDTH];
            gid_q   <= win_idx;
            ptr_q   <= ptr_d;
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            sel_q  <= ReqSel[win_idx*SEL_WIDTH +: SEL_WIDTH];
            data_q <= ReqData[win_idx*DATA_WIDTH +: DATA_WIDTH];
            gid_q  <= win_idx;
            ptr_q  <= ptr_d;
          end else if (consume) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Enable     = (state_q == ST_ISSUE);
  assign DemuxIn    = Enable;
  assign Sel        = sel_q;
  assign WriteData  = data_q;
  assign GrantId    = gid_q;
  assign IssueCount = cnt_q;

endmodule
